prog_fetch_ctrl: RTL and testbench
==================================

Name: prog_fetch_ctrl

Overview:
Controller for the dual-port program ROM with its registered output stage (two byte-read ports, one byte-write port). It owns the word program counter and sequences instruction fetch. Port A reads the high byte at {pc,1}; port B reads the low byte at {pc,0}. It delivers 16-bit instruction words to the decoder over a valid/ready handshake, and gives a byte-stream loader exclusive access to the write port during programming.

Parameters:
ADDR_W, 15, ROM byte-address width; PC width is ADDR_W-1.
RESET_VECTOR, 0, word address that the PC takes on reset and on run start.

Ports:
clk  in  1  system clock, all state on rising edge
clr_n  in  1  asynchronous active-low reset
run  in  1  level; start/continue fetching when high
ld_start  in  1  pulse; enter LOAD, byte write address := 0
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte
ld_done  in  1  pulse; leave LOAD to IDLE
ld_ready  out  1  loader byte accepted this cycle
ld_overflow  out  1  sticky; byte offered after address 2^ADDR_W-1 was written
redirect  in  1  branch/jump request from core
redirect_pc  in  ADDR_W-1  target word address
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decoder accepts the word
instr  out  16  {rom_qa, rom_qb}
instr_pc  out  ADDR_W-1  word address of instr
rom_addr_a  out  ADDR_W  {pc,1'b1}
rom_addr_b  out  ADDR_W  {pc,1'b0}
rom_en_reg  out  1  ROM output register enable
rom_clr_reg_n  out  1  ROM output register synchronous clear, active-low
rom_we  out  1  ROM write enable
rom_write_addr  out  ADDR_W  ROM byte write address
rom_data  out  8  ROM write data (= ld_data)
rom_qa, rom_qb  in  8 each  ROM registered outputs

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_VECTOR, write address=0.
  - ld_ready=0, ld_overflow=0, instr_valid=0, instr_pc=RESET_VECTOR.
  - rom_en_reg=0, rom_we=0, rom_clr_reg_n=1.
- ROM timing: addresses are driven combinationally from pc. Data appears on rom_qa/qb one cycle after a cycle with rom_en_reg=1.
- States: IDLE, LOAD, FETCH, VALID.
- IDLE:
  - ld_start -> LOAD.
  - Otherwise run=1 -> FETCH with pc=RESET_VECTOR (first entry after reset or after load); pc is kept after a run drop.
- FETCH: rom_en_reg=1, instr_valid=0; next state is VALID; instr_pc latches pc.
- VALID: instr_valid=1.
  - instr_ready=1 and run=1: pc+1 (wraps 2^(ADDR_W-1)-1 -> 0), rom_en_reg=1, instr_pc latches the new pc; stay in VALID. This gives back-to-back throughput of one word per cycle.
  - instr_ready=1 and run=0: -> IDLE, pc+1.
  - instr_ready=0: rom_en_reg=0; instr and instr_pc are held stable.
- redirect (FETCH or VALID): pc:=redirect_pc, -> FETCH, instr_valid=0 in the following cycle. A simultaneous instr_ready handshake completes for the current word, but pc takes redirect_pc rather than pc+1. Redirect is ignored in IDLE and LOAD.
- LOAD:
  - ld_ready=1 unless overflow. rom_we=ld_valid&ld_ready; rom_write_addr=write address.
  - Each accepted byte increments the address.
  - After byte 2^ADDR_W-1 is written, ld_ready=0. Any later ld_valid sets ld_overflow; the address does not wrap.
  - rom_en_reg=0 and instr_valid=0 throughout LOAD.
- ld_start priority: overrides every state and event. For one cycle: rom_clr_reg_n=0, write address:=0, ld_overflow:=0, enter LOAD. A fetch in progress is aborted.
- ld_done in LOAD -> IDLE and pc:=RESET_VECTOR. If ld_done and ld_valid arrive together, the byte is written first.
- Priority order: clr_n > ld_start > ld_done > redirect > handshake.

Decomposition:
- Shared package prog_mem_pkg: state encoding constants, ADDR_W, RESET_VECTOR.
- Natural sub-module: prog_loader_addr. It holds the load address counter, overflow flag and ld_ready logic. prog_fetch_ctrl holds the FSM and pc.

Test Plan:
1. Reset, then ld_start; load bytes 0x0C,0x94,0x2A,0x00; ld_done -> rom_write_addr 0..3 with rom_we on each byte; state returns to IDLE.
2. run=1 with instr_ready=1 held -> instr=0x940C, pc=0 after 2 cycles; instr=0x002A, pc=1 the next cycle; one word per cycle afterwards.
3. Hold instr_ready=0 for 5 cycles in VALID -> instr and instr_pc stable, rom_en_reg=0; on release, pc advances by exactly 1.
4. Redirect to 0x1234 during streaming -> instr_valid low for 1 cycle, then instr_pc=0x1234 with rom_addr_b=0x2468 and rom_addr_a=0x2469.
5. Load 32768 bytes plus 1 extra -> last write at 0x7FFF, ld_ready=0, ld_overflow=1; cleared by the next ld_start.
6. clr_n low in the middle of VALID, and separately ld_start in the middle of VALID -> all outputs at reset values (async); ld_start pulses rom_clr_reg_n low for 1 cycle and instr_valid drops.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory fetch path.
//   PROG_ADDR_W       : default ROM byte-address width (PC is one bit narrower)
//   PROG_RESET_VECTOR : default word address taken on reset and after a load
//   ST_*              : fetch controller state encoding (also visible on dbg_state)
package prog_mem_pkg;

  localparam int PROG_ADDR_W       = 15;
  localparam int PROG_RESET_VECTOR = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_VALID = 2'd3;

endpackage

// File: rtl/prog_loader_addr.sv
// Byte-write address generator for program loading.
// Ports:
//   clk, clr_n   : clock, asynchronous active-low reset
//   load_active  : controller is in LOAD
//   ld_start     : restart the load (address := 0, overflow cleared)
//   ld_valid     : loader offers a byte
//   wr_addr      : current ROM byte write address
//   ld_ready     : byte accepted this cycle
//   ld_overflow  : sticky, a byte was offered after the last address was written
// Handshake: a byte transfers in any cycle where ld_valid && ld_ready; the
// loader keeps ld_valid/ld_data stable until it sees ld_ready.
module prog_loader_addr #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load_active,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ld_ready,
  output logic              ld_overflow
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              accept;

  // No byte is taken in the ld_start cycle: the address is being reset.
  assign ld_ready = load_active & ~ld_start & ~full_q;
  assign accept   = ld_valid & ld_ready;

  always_comb begin
    addr_d = addr_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (ld_start) begin
      addr_d = '0;
      full_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (load_active) begin
      if (accept) begin
        // The top address is written once; the counter then parks there
        // instead of wrapping onto byte 0.
        if (addr_q == '1) full_d = 1'b1;
        else              addr_d = addr_q + ADDR_W'(1);
      end else if (ld_valid && full_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      addr_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign wr_addr     = addr_q;
  assign ld_overflow = ovf_q;

endmodule

// File: rtl/prog_fetch_ctrl.sv
// Fetch controller for the dual-port program ROM (registered outputs).
// Owns the word PC, streams 16-bit words to the decoder and hands the ROM
// write port to the byte loader during programming.
// Ports:
//   clk, clr_n                   : clock, asynchronous active-low reset
//   run                          : fetch while high
//   ld_start/ld_valid/ld_data/ld_done, ld_ready/ld_overflow : loader side
//   redirect, redirect_pc        : branch target from the core
//   instr_valid/instr_ready, instr, instr_pc : decoder side
//   rom_addr_a/b, rom_en_reg, rom_clr_reg_n  : ROM read port control
//   rom_we, rom_write_addr, rom_data         : ROM write port
//   rom_qa, rom_qb               : ROM registered read data (high, low byte)
//   dbg_state                    : current FSM state (ST_* encoding)
// Handshake: a word transfers in any cycle where instr_valid && instr_ready;
// while instr_valid is high and instr_ready is low, instr and instr_pc hold.
module prog_fetch_ctrl
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W       = PROG_ADDR_W,
  parameter int RESET_VECTOR = PROG_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              run,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_done,
  output logic              ld_ready,
  output logic              ld_overflow,
  input  logic              redirect,
  input  logic [ADDR_W-2:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [ADDR_W-2:0] instr_pc,
  output logic [ADDR_W-1:0] rom_addr_a,
  output logic [ADDR_W-1:0] rom_addr_b,
  output logic              rom_en_reg,
  output logic              rom_clr_reg_n,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_write_addr,
  output logic [7:0]        rom_data,
  input  logic [7:0]        rom_qa,
  input  logic [7:0]        rom_qb,
  output logic [1:0]        dbg_state
);

  localparam int              PC_W   = ADDR_W - 1;
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VECTOR);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            rom_en;

  // Next-state / next-pc. ld_start outranks everything; redirect outranks
  // the handshake but the current word still counts as delivered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rom_en  = 1'b0;
    if (ld_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_d = ST_FETCH;
        end
        ST_LOAD: begin
          if (ld_done) begin
            state_d = ST_IDLE;
            pc_d    = RST_PC;
          end
        end
        ST_FETCH: begin
          if (redirect) begin
            pc_d = redirect_pc;
          end else begin
            rom_en  = 1'b1;
            state_d = ST_VALID;
          end
        end
        ST_VALID: begin
          if (redirect) begin
            pc_d    = redirect_pc;
            state_d = ST_FETCH;
          end else if (instr_ready) begin
            pc_d = pc_q + PC_W'(1);
            if (run) rom_en  = 1'b1;
            else     state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // instr_pc tracks whatever address the ROM output register is loading.
  assign instr_pc_d = rom_en ? pc_d : instr_pc_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RST_PC;
      instr_pc_q <= RST_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  prog_loader_addr #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk         (clk),
    .clr_n       (clr_n),
    .load_active (state_q == ST_LOAD),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .wr_addr     (rom_write_addr),
    .ld_ready    (ld_ready),
    .ld_overflow (ld_overflow)
  );

  // Addresses follow the next pc so the ROM register captures the word that
  // will be presented in the following cycle (one word per cycle streaming).
  assign rom_addr_a    = {pc_d, 1'b1};
  assign rom_addr_b    = {pc_d, 1'b0};
  assign rom_en_reg    = rom_en;
  assign rom_clr_reg_n = ~ld_start;
  assign rom_we        = ld_valid & ld_ready;
  assign rom_data      = ld_data;

  // Masked by ld_start so an aborted fetch cannot complete a handshake.
  assign instr_valid = (state_q == ST_VALID) & ~ld_start;
  assign instr       = {rom_qa, rom_qb};
  assign instr_pc    = instr_pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
module tb_prog_fetch_ctrl;

  localparam int ADDR_W = 15;
  localparam int PC_W   = 14;
  localparam int NBYTES = 1 << ADDR_W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic run = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
  logic redirect = 1'b0, instr_ready = 1'b0;
  logic [7:0]        ld_data = 8'h00;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              ld_ready, ld_overflow, instr_valid, rom_en_reg, rom_clr_reg_n, rom_we;
  logic [15:0]       instr;
  logic [PC_W-1:0]   instr_pc;
  logic [ADDR_W-1:0] rom_addr_a, rom_addr_b, rom_write_addr;
  logic [7:0]        rom_data;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  prog_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_VECTOR(0)) dut (
    .clk(clk), .clr_n(clr_n), .run(run),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_done(ld_done),
    .ld_ready(ld_ready), .ld_overflow(ld_overflow),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b), .rom_en_reg(rom_en_reg),
    .rom_clr_reg_n(rom_clr_reg_n), .rom_we(rom_we), .rom_write_addr(rom_write_addr),
    .rom_data(rom_data), .rom_qa(qa), .rom_qb(qb), .dbg_state(dbg_state)
  );

  // ---------------- ROM model (registered outputs) ----------------
  logic [7:0] mem [NBYTES] = '{default: 8'h00};
  logic [7:0] qa = 8'h00, qb = 8'h00;

  always @(posedge clk) begin
    if (rom_we) mem[rom_write_addr] <= rom_data;
    if (!rom_clr_reg_n) begin
      qa <= 8'h00;
      qb <= 8'h00;
    end else if (rom_en_reg) begin
      qa <= mem[rom_addr_a];
      qb <= mem[rom_addr_b];
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] img [NBYTES];   // program image loaded in the full-load test

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [PC_W-1:0] p);
    return {img[{p, 1'b1}], img[{p, 1'b0}]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic s, v; logic [7:0] d; logic dn, r, rd;
    logic [1:0] e_st; logic e_lr, e_we; logic [14:0] e_wa; logic e_cn, e_iv, e_en;
    logic [14:0] e_ab; logic [15:0] e_ins; logic [13:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic dn, logic r, logic rd,
                              logic [1:0] st, logic lr, logic we, logic [14:0] wa, logic cn,
                              logic iv, logic en, logic [14:0] ab, logic [15:0] ins,
                              logic [13:0] ipc);
    vec_t t;
    t.s = s; t.v = v; t.d = d; t.dn = dn; t.r = r; t.rd = rd;
    t.e_st = st; t.e_lr = lr; t.e_we = we; t.e_wa = wa; t.e_cn = cn;
    t.e_iv = iv; t.e_en = en; t.e_ab = ab; t.e_ins = ins; t.e_ipc = ipc;
    return t;
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] tgt;
    int bad, gap, hs, got;

    for (int i = 0; i < NBYTES; i++) img[i] = 8'((i * 37) ^ (i >> 7));

    // Reset values while clr_n is held low.
    @(negedge clk);
    check("rst_state", dbg_state, 2'd0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_ovf", ld_overflow, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr_pc", instr_pc, 14'h0);
    check("rst_en", rom_en_reg, 1'b0);
    check("rst_we", rom_we, 1'b0);
    check("rst_clr_n", rom_clr_reg_n, 1'b1);
    check("rst_waddr", rom_write_addr, 15'h0);
    next_cycle();
    clr_n = 1'b1;

    // Load 4 bytes, then stream, then stall for 5 cycles, then release.
    //            s  v  d      dn r  rd  st lr we wa cn iv en ab  ins       ipc
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 8'h0C, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 8'h94, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 8'h2A, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'h55, 0, 0, 0, 1, 1, 0, 3, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 1, 1, 3, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 4, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 2, 0, 0, 4, 1, 0, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 3, 0, 0, 4, 1, 1, 1, 2, 16'h940C, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 3, 0, 0, 4, 1, 1, 0, 2, 16'h002A, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 3, 0, 0, 4, 1, 1, 1, 4, 16'h002A, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 3, 0, 0, 4, 1, 1, 0, 4, 16'h0000, 2));

    foreach (vecs[i]) begin
      ld_start = vecs[i].s; ld_valid = vecs[i].v; ld_data = vecs[i].d;
      ld_done = vecs[i].dn; run = vecs[i].r; instr_ready = vecs[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d.state", i), dbg_state, vecs[i].e_st);
      check($sformatf("vec%0d.ld_ready", i), ld_ready, vecs[i].e_lr);
      check($sformatf("vec%0d.rom_we", i), rom_we, vecs[i].e_we);
      check($sformatf("vec%0d.waddr", i), rom_write_addr, vecs[i].e_wa);
      check($sformatf("vec%0d.clr_n", i), rom_clr_reg_n, vecs[i].e_cn);
      check($sformatf("vec%0d.valid", i), instr_valid, vecs[i].e_iv);
      check($sformatf("vec%0d.en", i), rom_en_reg, vecs[i].e_en);
      check($sformatf("vec%0d.addr_b", i), rom_addr_b, vecs[i].e_ab);
      check($sformatf("vec%0d.addr_a", i), rom_addr_a, vecs[i].e_ab | 15'h1);
      check($sformatf("vec%0d.instr", i), instr, vecs[i].e_ins);
      check($sformatf("vec%0d.instr_pc", i), instr_pc, vecs[i].e_ipc);
      next_cycle();
    end
    ld_valid = 1'b0; ld_done = 1'b0;

    // Redirect to 0x1234 while a word is being accepted.
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 14'h1234;
    @(negedge clk);
    check("redir_cur_valid", instr_valid, 1'b1);
    check("redir_addr_b", rom_addr_b, 15'h2468);
    check("redir_en", rom_en_reg, 1'b0);
    next_cycle();
    redirect = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    check("redir_gap_valid", instr_valid, 1'b0);
    check("redir_fetch_en", rom_en_reg, 1'b1);
    check("redir_fetch_addr_a", rom_addr_a, 15'h2469);
    next_cycle();
    @(negedge clk);
    check("redir_valid", instr_valid, 1'b1);
    check("redir_instr_pc", instr_pc, 14'h1234);
    check("redir_addr_b2", rom_addr_b, 15'h2468);
    check("redir_addr_a2", rom_addr_a, 15'h2469);

    // Asynchronous reset in the middle of VALID.
    #2;
    clr_n = 1'b0;
    #1;
    check("areset_state", dbg_state, 2'd0);
    check("areset_valid", instr_valid, 1'b0);
    check("areset_instr_pc", instr_pc, 14'h0);
    check("areset_en", rom_en_reg, 1'b0);
    check("areset_waddr", rom_write_addr, 15'h0);
    check("areset_ld_ready", ld_ready, 1'b0);
    check("areset_clr_n", rom_clr_reg_n, 1'b1);
    run = 1'b0;
    next_cycle();
    clr_n = 1'b1;

    // ld_start in the middle of VALID aborts the fetch.
    run = 1'b1; instr_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("abort_pre_valid", instr_valid, 1'b1);
    check("abort_pre_instr", instr, 16'h940C);
    check("abort_pre_pc", instr_pc, 14'h0);
    next_cycle();
    ld_start = 1'b1;
    @(negedge clk);
    check("abort_clr_n", rom_clr_reg_n, 1'b0);
    check("abort_valid", instr_valid, 1'b0);
    check("abort_en", rom_en_reg, 1'b0);
    next_cycle();
    ld_start = 1'b0; run = 1'b0;
    @(negedge clk);
    check("abort_state", dbg_state, 2'd1);
    check("abort_valid2", instr_valid, 1'b0);
    check("abort_instr_cleared", instr, 16'h0000);
    check("abort_clr_n2", rom_clr_reg_n, 1'b1);
    check("abort_ld_ready", ld_ready, 1'b1);
    next_cycle();
    ld_done = 1'b1;
    next_cycle();
    ld_done = 1'b0;
    @(negedge clk);
    check("abort_done_idle", dbg_state, 2'd0);

    // Full-size load plus one extra byte.
    next_cycle();
    ld_start = 1'b1;
    next_cycle();
    ld_start = 1'b0;
    bad = 0;
    for (int i = 0; i < NBYTES; i++) begin
      ld_valid = 1'b1; ld_data = img[i];
      @(negedge clk);
      if (!(rom_we === 1'b1 && rom_write_addr === 15'(i) && rom_data === img[i])) bad++;
      next_cycle();
    end
    check("full_load_bad_bytes", bad, 0);
    ld_data = 8'hEE;
    @(negedge clk);
    check("full_ld_ready", ld_ready, 1'b0);
    check("full_we", rom_we, 1'b0);
    check("full_waddr", rom_write_addr, 15'h7FFF);
    check("full_ovf_pre", ld_overflow, 1'b0);
    next_cycle();
    ld_valid = 1'b0;
    @(negedge clk);
    check("full_ovf_set", ld_overflow, 1'b1);
    next_cycle();
    ld_start = 1'b1;
    next_cycle();
    ld_start = 1'b0;
    @(negedge clk);
    check("full_ovf_clr", ld_overflow, 1'b0);
    check("full_waddr_clr", rom_write_addr, 15'h0);
    check("full_ld_ready_again", ld_ready, 1'b1);
    next_cycle();
    ld_done = 1'b1;
    next_cycle();
    ld_done = 1'b0;

    // Randomized streaming against a transaction-level model: every valid
    // word must be the next address in program order, except after a
    // redirect, and its data must match the loaded image.
    run = 1'b1; instr_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) got = 1;
      else next_cycle();
    end
    check("rand_first_valid", got, 1);
    next_cycle();
    exp_pc = '0; gap = 0; hs = 0;
    for (int c = 0; c < 1500; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 14'h3FFC + 14'($urandom_range(0, 3));
      else                           tgt = 14'($urandom_range(0, 16383));
      redirect_pc = tgt;
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        gap = 0;
        check("rand_instr_pc", instr_pc, exp_pc);
        check("rand_instr", instr, word_of(exp_pc));
        if (instr_ready) hs++;
      end else begin
        gap++;
        check("rand_fetch_gap", (gap <= 1), 1'b1);
        if (redirect) gap = 0;
      end
      if (redirect) exp_pc = redirect_pc;
      else if (instr_valid === 1'b1 && instr_ready) exp_pc = exp_pc + 14'd1;
      next_cycle();
    end
    check("rand_throughput", (hs > 500), 1'b1);

    // PC wrap from the top word back to 0.
    redirect = 1'b1; redirect_pc = 14'h3FFF; instr_ready = 1'b0;
    next_cycle();
    redirect = 1'b0;
    next_cycle();
    instr_ready = 1'b1;
    @(negedge clk);
    check("wrap_pc_top", instr_pc, 14'h3FFF);
    check("wrap_instr_top", instr, word_of(14'h3FFF));
    check("wrap_addr_b", rom_addr_b, 15'h0000);
    next_cycle();
    instr_ready = 1'b0;
    @(negedge clk);
    check("wrap_pc_zero", instr_pc, 14'h0);
    check("wrap_instr_zero", instr, word_of(14'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
